// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// lzb_mask works on a fixed-width padded digit vector; callers pass the live digit count.
package display_pkg;

  localparam int DEF_NUM_DIGITS = 8;
  localparam int BCD_W          = 4;
  localparam int MAX_DIGITS     = 16;

  // Inactive levels of the active-low anode and decimal-point drives
  localparam logic ANODE_OFF = 1'b1;
  localparam logic DP_OFF    = 1'b1;

  // Digit i is blanked when it and every digit above it is zero; digit 0 always shows.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(
    input logic [BCD_W*MAX_DIGITS-1:0] digits,
    input int                          n
  );
    logic [MAX_DIGITS-1:0] blank;
    logic                  all_zero;
    blank    = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n) begin
        all_zero = all_zero & (digits[i*BCD_W +: BCD_W] == '0);
        blank[i] = all_zero && (i != 0);
      end
    end
    return blank;
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Prescaler and digit-slot counter. Emits frame_start on the cycle the shadow
// registers must latch: the last slot's wrap, and the first cycle out of reset.
module display_scan_timer #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int PRE_W      = $clog2(SCAN_DIV),
  parameter int SLOT_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PRE_W-1:0]  o_pre,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_frame_start
);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]  r_pre;
  logic [SLOT_W-1:0] r_slot;
  logic              r_first;
  logic              w_slot_adv;

  // The counters hold at slot 0 / pre 0 during the post-reset latch cycle so the
  // first displayed slot-0 cycle already uses freshly captured shadow values.
  assign w_slot_adv    = !r_first && (r_pre == PRE_LAST);
  assign o_frame_start = r_first || (w_slot_adv && (r_slot == SLOT_LAST));
  assign o_pre         = r_pre;
  assign o_slot        = r_slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_slot  <= '0;
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (w_slot_adv) begin
        r_pre  <= '0;
        r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
      end else if (!r_first) begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: frame-latched shadow config,
// per-digit enable, PWM brightness, guard time and leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 16,
  parameter int BRIGHT_W   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BCD_W*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic [NUM_DIGITS-1:0]         en_i,
  input  logic [BRIGHT_W-1:0]           bright_i,
  input  logic                          lzb_i,
  output logic [NUM_DIGITS-1:0]         anode_o,
  output logic [BCD_W-1:0]              bcd_o,
  output logic                          dp_o,
  output logic                          frame_tick_o
);

  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] GUARD_P = PRE_W'(GUARD);

  logic [PRE_W-1:0]              w_pre;
  logic [SLOT_W-1:0]             w_slot;
  logic                          w_frame_start;

  logic [BCD_W*NUM_DIGITS-1:0]   r_sh_digits;
  logic [NUM_DIGITS-1:0]         r_sh_dp;
  logic [NUM_DIGITS-1:0]         r_sh_en;
  logic [NUM_DIGITS-1:0]         r_sh_blank;
  logic [BRIGHT_W-1:0]           r_sh_bright;
  logic [BRIGHT_W-1:0]           r_pwm;
  logic                          r_frame_arm;

  logic [NUM_DIGITS-1:0]         r_anode;
  logic [BCD_W-1:0]              r_bcd;
  logic                          r_dp;
  logic                          r_tick;

  logic [BCD_W*MAX_DIGITS-1:0]   w_dig_pad;
  logic [NUM_DIGITS-1:0]         w_blank_next;
  logic                          w_lit;
  logic [NUM_DIGITS-1:0]         w_anode_next;

  display_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .PRE_W      (PRE_W),
    .SLOT_W     (SLOT_W)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .o_pre         (w_pre),
    .o_slot        (w_slot),
    .o_frame_start (w_frame_start)
  );

  assign w_dig_pad    = (BCD_W*MAX_DIGITS)'(digits_i);
  assign w_blank_next = lzb_i ? NUM_DIGITS'(lzb_mask(w_dig_pad, NUM_DIGITS)) : '0;

  always_comb begin
    w_lit = (w_pre >= GUARD_P) && r_sh_en[w_slot] && !r_sh_blank[w_slot]
            && (r_pwm <= r_sh_bright);
    w_anode_next = {NUM_DIGITS{ANODE_OFF}};
    if (w_lit) begin
      w_anode_next[w_slot] = ~ANODE_OFF;
    end
  end

  // r_frame_arm marks the first slot-0 state of a frame; its registered copy is the tick,
  // so the tick lines up with the first slot-0 output cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_digits <= '0;
      r_sh_dp     <= '0;
      r_sh_en     <= '0;
      r_sh_blank  <= '0;
      r_sh_bright <= '0;
      r_pwm       <= '0;
      r_frame_arm <= 1'b0;
      r_anode     <= {NUM_DIGITS{ANODE_OFF}};
      r_bcd       <= '0;
      r_dp        <= DP_OFF;
      r_tick      <= 1'b0;
    end else begin
      r_pwm       <= r_pwm + 1'b1;
      r_frame_arm <= w_frame_start;
      if (w_frame_start) begin
        r_sh_digits <= digits_i;
        r_sh_dp     <= dp_i;
        r_sh_en     <= en_i;
        r_sh_blank  <= w_blank_next;
        r_sh_bright <= bright_i;
      end
      r_anode <= w_anode_next;
      r_bcd   <= r_sh_digits[w_slot*BCD_W +: BCD_W];
      r_dp    <= w_lit ? ~r_sh_dp[w_slot] : DP_OFF;
      r_tick  <= r_frame_arm;
    end
  end

  assign anode_o      = r_anode;
  assign bcd_o        = r_bcd;
  assign dp_o         = r_dp;
  assign frame_tick_o = r_tick;

endmodule
